// File: rtl/hdmi_tx_mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : hdmi_tx_mode_ctrl                                              |
// | Desc    : Avalon-MM owner of the HDMI TX mode word. Applies target       |
// |           changes via mode_req/mode_ack, then holds off the next change. |
// |           Optional irq output and IRQ_MASK register: HDMI_TX_MODE_IRQ_EN |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hdmi_tx_mode_ctrl #(
   parameter int                DATA_W         = 8,
   parameter logic [DATA_W-1:0] RESET_VALUE    = '0,
   parameter int                HOLDOFF_CYCLES = 16,
   parameter int                ACK_TIMEOUT    = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic [DATA_W-1:0] out_port,
   output logic              mode_req,
   input  logic              mode_ack
`ifdef HDMI_TX_MODE_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam logic [2:0] c_ADDR_TARGET   = 3'd0;
   localparam logic [2:0] c_ADDR_SET      = 3'd1;
   localparam logic [2:0] c_ADDR_CLEAR    = 3'd2;
   localparam logic [2:0] c_ADDR_STATUS   = 3'd3;
   localparam logic [2:0] c_ADDR_APPLIED  = 3'd4;
`ifdef HDMI_TX_MODE_IRQ_EN
   localparam logic [2:0] c_ADDR_IRQ_MASK = 3'd5;
   localparam int         c_MSK_BITS      = (DATA_W < 2) ? DATA_W : 2;
`endif

   localparam int c_ST_BITS = (DATA_W < 4) ? DATA_W : 4;

   // One counter serves both the REQ timeout and the HOLD hold-off.
   localparam int c_CNT_MAX = (HOLDOFF_CYCLES > ACK_TIMEOUT) ? HOLDOFF_CYCLES : ACK_TIMEOUT;
   localparam int c_CNT_W   = (c_CNT_MAX > 0) ? $clog2(c_CNT_MAX + 1) : 1;
   localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? c_CNT_W'(HOLDOFF_CYCLES - 1) : '0;
   localparam logic [c_CNT_W-1:0] c_TO_LAST   = (ACK_TIMEOUT > 0) ? c_CNT_W'(ACK_TIMEOUT - 1) : '0;
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_target;
   logic [DATA_W-1:0]   r_out_port;
   logic                r_mode_req;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                r_done;
   logic                r_timeout;

   logic                w_wr;
   logic                w_wr_status;
   logic                w_busy;
   logic                w_pending;
   logic                w_done_set;
   logic                w_to_set;
   logic                w_clr_done;
   logic                w_clr_timeout;
   logic [3:0]          w_flags;
   logic [DATA_W-1:0]   w_status;

   assign w_wr        = chipselect & ~write_n;
   assign w_wr_status = w_wr & (address == c_ADDR_STATUS);
   assign w_busy      = (r_state != ST_IDLE);
   assign w_pending   = (r_target != r_out_port);
   assign w_flags     = {r_timeout, r_done, w_pending, w_busy};

   // Ack has priority over a timeout landing on the same edge.
   assign w_done_set  = (r_state == ST_REQ) & mode_ack;
   assign w_to_set    = (r_state == ST_REQ) & ~mode_ack & (ACK_TIMEOUT != 0) & (r_cnt == c_TO_LAST);

   always_comb begin
      w_clr_done    = 1'b0;
      w_clr_timeout = 1'b0;
      for (int i = 0; i < c_ST_BITS; i++) begin
         if (i == 2) w_clr_done    = w_wr_status & writedata[i];
         if (i == 3) w_clr_timeout = w_wr_status & writedata[i];
      end
   end

   always_comb begin
      w_status = '0;
      for (int i = 0; i < c_ST_BITS; i++) begin
         w_status[i] = w_flags[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_target <= RESET_VALUE;
      end else if (w_wr) begin
         case (address)
            c_ADDR_TARGET: r_target <= writedata;
            c_ADDR_SET:    r_target <= r_target | writedata;
            c_ADDR_CLEAR:  r_target <= r_target & ~writedata;
            default:       r_target <= r_target;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_out_port <= RESET_VALUE;
         r_mode_req <= 1'b0;
         r_cnt      <= '0;
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pending) begin
                  r_out_port <= r_target;
                  r_mode_req <= 1'b1;
                  r_cnt      <= '0;
                  r_state    <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mode_ack) begin
                  r_mode_req <= 1'b0;
                  if (HOLDOFF_CYCLES == 0) begin
                     r_cnt   <= '0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_cnt   <= c_HOLD_LOAD;
                     r_state <= ST_HOLD;
                  end
               end else if (w_to_set) begin
                  r_mode_req <= 1'b0;
                  r_cnt      <= '0;
                  r_state    <= ST_IDLE;
               end else if (ACK_TIMEOUT != 0) begin
                  r_cnt <= r_cnt + c_CNT_ONE;
               end
            end
            ST_HOLD: begin
               if (r_cnt == '0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - c_CNT_ONE;
               end
            end
            default: begin
               r_mode_req <= 1'b0;
               r_cnt      <= '0;
               r_state    <= ST_IDLE;
            end
         endcase
         // A flag raised on the same edge as its W1C clear stays set.
         r_done    <= w_done_set | (r_done & ~w_clr_done);
         r_timeout <= w_to_set | (r_timeout & ~w_clr_timeout);
      end
   end

   assign out_port = r_out_port;
   assign mode_req = r_mode_req;

`ifdef HDMI_TX_MODE_IRQ_EN
   logic [1:0]        r_irq_mask;
   logic              r_irq;
   logic [1:0]        w_mask_wd;
   logic [DATA_W-1:0] w_mask_rd;

   always_comb begin
      w_mask_wd = '0;
      w_mask_rd = '0;
      for (int i = 0; i < c_MSK_BITS; i++) begin
         w_mask_wd[i] = writedata[i];
         w_mask_rd[i] = r_irq_mask[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq_mask <= 2'b00;
         r_irq      <= 1'b0;
      end else begin
         if (w_wr && (address == c_ADDR_IRQ_MASK)) begin
            r_irq_mask <= w_mask_wd;
         end
         r_irq <= (r_done & r_irq_mask[0]) | (r_timeout & r_irq_mask[1]);
      end
   end

   assign irq = r_irq;
`endif

   always_comb begin
      readdata = '0;
      case (address)
         c_ADDR_TARGET:   readdata = r_target;
         c_ADDR_STATUS:   readdata = w_status;
         c_ADDR_APPLIED:  readdata = r_out_port;
`ifdef HDMI_TX_MODE_IRQ_EN
         c_ADDR_IRQ_MASK: readdata = w_mask_rd;
`endif
         default:         readdata = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_tx_mode_ctrl.sv
`default_nettype none
// Testbench for hdmi_tx_mode_ctrl: directed vector table and sequences,
// then randomized traffic against a cycle-level reference model.
module tb_hdmi_tx_mode_ctrl;

   localparam int DW   = 8;
   localparam int HOLD = 16;
   localparam int ATO  = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [DW-1:0] writedata;
   logic [DW-1:0] readdata;
   logic [DW-1:0] out_port;
   logic          mode_req;
   logic          mode_ack;
`ifdef HDMI_TX_MODE_IRQ_EN
   logic          irq;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hdmi_tx_mode_ctrl #(
      .DATA_W         (DW),
      .RESET_VALUE    (8'h00),
      .HOLDOFF_CYCLES (HOLD),
      .ACK_TIMEOUT    (ATO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .mode_req   (mode_req),
      .mode_ack   (mode_ack)
`ifdef HDMI_TX_MODE_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   // Reference model: mode request is "live" for a counted number of cycles,
   // hold-off is a number of remaining cycles; busy means either is active.
   logic [7:0] m_target  = 8'h00;
   logic [7:0] m_applied = 8'h00;
   bit         m_req     = 1'b0;
   int         m_req_age = 0;
   int         m_hold    = 0;
   bit         m_done    = 1'b0;
   bit         m_to      = 1'b0;
   logic [1:0] m_mask    = 2'b00;
   bit         m_irq     = 1'b0;

   function automatic logic [7:0] model_rd(input logic [2:0] a);
      bit busy;
      busy = m_req || (m_hold > 0);
      case (a)
         3'd0: return m_target;
         3'd3: return {4'h0, m_to, m_done, (m_target != m_applied), busy};
         3'd4: return m_applied;
`ifdef HDMI_TX_MODE_IRQ_EN
         3'd5: return {6'h00, m_mask};
`endif
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_update();
      logic [7:0] n_target;
      bit wr, d_set, t_set, n_irq;
      if (reset) begin
         m_target = 8'h00; m_applied = 8'h00; m_req = 0; m_req_age = 0;
         m_hold = 0; m_done = 0; m_to = 0; m_mask = 2'b00; m_irq = 0;
         return;
      end
      wr = chipselect && !write_n;
      n_target = m_target;
      if (wr && address == 3'd0) n_target = writedata;
      if (wr && address == 3'd1) n_target = m_target | writedata;
      if (wr && address == 3'd2) n_target = m_target & ~writedata;
      n_irq = (m_done && m_mask[0]) || (m_to && m_mask[1]);
      d_set = 0; t_set = 0;
      if (m_req) begin
         if (mode_ack) begin
            m_req = 0; d_set = 1; m_hold = HOLD;
         end else begin
            m_req_age = m_req_age + 1;
            if (ATO != 0 && m_req_age >= ATO) begin
               m_req = 0; t_set = 1;
            end
         end
      end else if (m_hold > 0) begin
         m_hold = m_hold - 1;
      end else if (m_target != m_applied) begin
         m_applied = m_target; m_req = 1; m_req_age = 0;
      end
      m_done = d_set || (m_done && !(wr && address == 3'd3 && writedata[2]));
      m_to   = t_set || (m_to && !(wr && address == 3'd3 && writedata[3]));
`ifdef HDMI_TX_MODE_IRQ_EN
      if (wr && address == 3'd5) m_mask = writedata[1:0];
`endif
      m_irq = n_irq;
      m_target = n_target;
   endtask

   task automatic drive(input logic r, input logic [2:0] a, input logic c, input logic w,
                        input logic [7:0] d, input logic k);
      reset = r; address = a; chipselect = c; write_n = ~w; writedata = d; mode_ack = k;
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic ticks(input int n);
      idle();
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr_cycle(input logic [2:0] a, input logic [7:0] d);
      drive(1'b0, a, 1'b1, 1'b1, d, 1'b0);
      tick();
      idle();
   endtask

   task automatic ack_cycle();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      idle();
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic read_chk(input string nm, input logic [2:0] a, input logic [7:0] exp);
      drive(1'b0, a, 1'b1, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      chk(nm, readdata, exp);
   endtask

   typedef struct packed {
      logic       rst;
      logic [2:0] addr;
      logic       cs;
      logic       wr;
      logic [7:0] wd;
      logic       ack;
      logic [7:0] e_out;
      logic       e_req;
      logic [7:0] e_rd;
   } vec_t;

   vec_t vt [9];

   initial begin
      bit saw_req;

      // Basic change: write 0x35, ack three cycles after the request rises.
      vt[0] = '{1'b0, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
      vt[1] = '{1'b0, 3'd0, 1'b1, 1'b1, 8'h35, 1'b0, 8'h00, 1'b0, 8'h00};
      vt[2] = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h35};
      vt[3] = '{1'b0, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 8'h35, 1'b1, 8'h01};
      vt[4] = '{1'b0, 3'd4, 1'b1, 1'b0, 8'h00, 1'b0, 8'h35, 1'b1, 8'h35};
      vt[5] = '{1'b0, 3'd3, 1'b1, 1'b0, 8'h00, 1'b1, 8'h35, 1'b1, 8'h01};
      vt[6] = '{1'b0, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 8'h35, 1'b0, 8'h05};
      vt[7] = '{1'b0, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h35, 1'b0, 8'h00};
      vt[8] = '{1'b0, 3'd7, 1'b1, 1'b0, 8'h00, 1'b0, 8'h35, 1'b0, 8'h00};

      idle();
      reset = 1'b1;
      tick(); tick();
      idle();

      foreach (vt[i]) begin
         drive(vt[i].rst, vt[i].addr, vt[i].cs, vt[i].wr, vt[i].wd, vt[i].ack);
         @(negedge clk);
         chk($sformatf("vec%0d_out", i), out_port, vt[i].e_out);
         chk($sformatf("vec%0d_req", i), {7'h0, mode_req}, {7'h0, vt[i].e_req});
         chk($sformatf("vec%0d_rd", i), readdata, vt[i].e_rd);
         tick();
      end
      // Hold-off lasts exactly HOLD cycles after the ack edge.
      for (int i = 4; i <= HOLD; i++) begin
         read_chk("hold_busy", 3'd3, 8'h05);
         tick();
      end
      read_chk("hold_over", 3'd3, 8'h04);

      // SET then CLEAR during REQ: coalesced change applied after hold-off.
      wr_cycle(3'd1, 8'h80);
      tick();
      drive(1'b0, 3'd2, 1'b1, 1'b1, 8'h01, 1'b0);
      @(negedge clk);
      chk("setclr_out_req", out_port, 8'hB5);
      chk("setclr_req", {7'h0, mode_req}, 8'h01);
      tick();
      read_chk("setclr_status", 3'd3, 8'h07);
      chk("setclr_out_kept", out_port, 8'hB5);
      ack_cycle();
      ticks(HOLD);
      @(negedge clk);
      chk("setclr_idle_out", out_port, 8'hB5);
      chk("setclr_idle_req", {7'h0, mode_req}, 8'h00);
      tick();
      @(negedge clk);
      chk("setclr_second_out", out_port, 8'hB4);
      chk("setclr_second_req", {7'h0, mode_req}, 8'h01);
      ack_cycle();
      ticks(HOLD + 1);

      // Ack timeout after ATO cycles, then W1C of the timeout flag.
      wr_cycle(3'd3, 8'h04);
      read_chk("to_cleared_done", 3'd3, 8'h00);
      wr_cycle(3'd0, 8'h5A);
      tick();
      @(negedge clk);
      chk("to_req_up", {7'h0, mode_req}, 8'h01);
      ticks(ATO - 1);
      @(negedge clk);
      chk("to_req_last", {7'h0, mode_req}, 8'h01);
      tick();
      @(negedge clk);
      chk("to_req_drop", {7'h0, mode_req}, 8'h00);
      chk("to_out_kept", out_port, 8'h5A);
      read_chk("to_status", 3'd3, 8'h08);
      wr_cycle(3'd3, 8'h08);
      read_chk("to_w1c", 3'd3, 8'h00);

      // Ack on the same edge the timeout would fire: ack wins.
      wr_cycle(3'd0, 8'h5B);
      tick();
      ticks(ATO - 1);
      ack_cycle();
      read_chk("ack_vs_to_status", 3'd3, 8'h05);
      chk("ack_vs_to_req", {7'h0, mode_req}, 8'h00);
      ticks(HOLD + 1);

      // Cancel during HOLD; ack edge also carries W1C of done (set wins).
      wr_cycle(3'd0, 8'h11);
      tick();
      drive(1'b0, 3'd3, 1'b1, 1'b1, 8'h0C, 1'b1);
      tick();
      wr_cycle(3'd0, 8'h22);
      read_chk("cancel_pending", 3'd3, 8'h07);
      wr_cycle(3'd0, 8'h11);
      read_chk("cancel_cleared", 3'd3, 8'h05);
      saw_req = 1'b0;
      idle();
      for (int i = 0; i < HOLD + 4; i++) begin
         @(negedge clk);
         if (mode_req) saw_req = 1'b1;
         tick();
      end
      chk("cancel_no_req", {7'h0, saw_req}, 8'h00);
      chk("cancel_out", out_port, 8'h11);
      read_chk("cancel_status", 3'd3, 8'h04);

      // Reset in the middle of a request; ack in IDLE is ignored.
      wr_cycle(3'd0, 8'h77);
      tick();
      @(negedge clk);
      chk("rst_req_before", {7'h0, mode_req}, 8'h01);
      drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      read_chk("rst_status", 3'd3, 8'h00);
      chk("rst_req", {7'h0, mode_req}, 8'h00);
      chk("rst_out", out_port, 8'h00);
      ack_cycle();
      tick();
      read_chk("idle_ack_status", 3'd3, 8'h00);
      chk("idle_ack_req", {7'h0, mode_req}, 8'h00);

`ifdef HDMI_TX_MODE_IRQ_EN
      wr_cycle(3'd5, 8'h01);
      read_chk("irq_mask_rd", 3'd5, 8'h01);
      wr_cycle(3'd0, 8'h42);
      tick();
      @(negedge clk);
      chk("irq_before", {7'h0, irq}, 8'h00);
      ack_cycle();
      @(negedge clk);
      chk("irq_same_edge", {7'h0, irq}, 8'h00);
      tick();
      @(negedge clk);
      chk("irq_rise", {7'h0, irq}, 8'h01);
      wr_cycle(3'd3, 8'h04);
      @(negedge clk);
      chk("irq_hold_after_w1c", {7'h0, irq}, 8'h01);
      tick();
      @(negedge clk);
      chk("irq_fall", {7'h0, irq}, 8'h00);
      ticks(HOLD + 1);
`else
      wr_cycle(3'd5, 8'hFF);
      read_chk("addr5_zero", 3'd5, 8'h00);
`endif

      // Randomized traffic against the reference model.
      drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick(); tick();
      for (int n = 0; n < 2500; n++) begin
         reset      = ($urandom_range(0, 299) == 0);
         chipselect = ($urandom_range(0, 1) == 0);
         write_n    = ($urandom_range(0, 3) != 0);
         address    = 3'($urandom_range(0, 7));
         writedata  = ($urandom_range(0, 3) == 0) ? m_applied : 8'($urandom);
         mode_ack   = ($urandom_range(0, 5) == 0);
         @(negedge clk);
         chk("rnd_out", out_port, m_applied);
         chk("rnd_req", {7'h0, mode_req}, {7'h0, m_req});
         chk("rnd_rd", readdata, model_rd(address));
`ifdef HDMI_TX_MODE_IRQ_EN
         chk("rnd_irq", {7'h0, irq}, {7'h0, m_irq});
`endif
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
